// File: rtl/credit_switch_allocator.sv
// Per-output round-robin switch allocator with credit-based downstream flow control.
// Grants are combinational from current requests and registered credit/pointer state.
module credit_switch_allocator #(
    parameter int unsigned N            = 5,
    parameter int unsigned M            = 5,
    parameter int unsigned CREDIT_DEPTH = 4,
    localparam int unsigned CW          = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0][M-1:0]  i_output_req,
    input  logic [M-1:0]         i_credit_ret,
    output logic [M-1:0][N-1:0]  o_output_grant,
    output logic [N-1:0]         o_input_grant,
    output logic [M-1:0]         o_data_val,
    output logic [M-1:0][CW-1:0] o_credit,
    output logic                 o_credit_err
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0][M-1:0]  req_san;
    logic [M-1:0][N-1:0]  req_col;
    logic [M-1:0]         eligible;
    logic [M-1:0][N-1:0]  gnt;
    logic [M-1:0][PW-1:0] gnt_idx;
    logic [M-1:0]         gnt_any;
    logic [M-1:0][PW-1:0] ptr;
    logic [M-1:0][PW-1:0] ptr_nxt;
    logic [M-1:0][CW-1:0] credit;
    logic [M-1:0][CW-1:0] credit_nxt;
    logic                 err_nxt;

    // Keep only the lowest set bit of each request word, then view requests per output.
    always_comb begin
        req_san = '0;
        req_col = '0;
        for (int i = 0; i < int'(N); i++) begin
            req_san[i] = i_output_req[i] & (~i_output_req[i] + M'(1));
        end
        for (int j = 0; j < int'(M); j++) begin
            for (int i = 0; i < int'(N); i++) begin
                req_col[j][i] = req_san[i][j];
            end
        end
    end

    // An output with no credit is invisible to arbitration this cycle.
    always_comb begin
        eligible = '0;
        for (int j = 0; j < int'(M); j++) begin
            eligible[j] = (credit[j] != '0);
        end
    end

    // Cyclic search starting at ptr[j]; first requester found wins.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = '0;
        for (int j = 0; j < int'(M); j++) begin
            for (int k = 0; k < int'(N); k++) begin
                idx = int'(ptr[j]) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!gnt_any[j] && eligible[j] && req_col[j][PW'(idx)]) begin
                    gnt[j][PW'(idx)] = 1'b1;
                    gnt_idx[j]       = PW'(idx);
                    gnt_any[j]       = 1'b1;
                end
            end
        end
    end

    // Outputs are forced low for as long as reset is held, independent of the clock.
    always_comb begin
        o_output_grant = reset ? '0 : gnt;
        o_data_val     = '0;
        o_input_grant  = '0;
        for (int j = 0; j < int'(M); j++) begin
            o_data_val[j] = |o_output_grant[j];
            o_input_grant = o_input_grant | o_output_grant[j];
        end
    end

    assign o_credit = credit;

    // Pointer moves past the winner; credit = credit - grant + return, saturating at depth.
    always_comb begin
        ptr_nxt    = ptr;
        credit_nxt = credit;
        err_nxt    = o_credit_err;
        for (int j = 0; j < int'(M); j++) begin
            if (gnt_any[j]) begin
                ptr_nxt[j] = (gnt_idx[j] == PW'(N - 1)) ? '0 : gnt_idx[j] + PW'(1);
            end
            if (gnt_any[j] && !i_credit_ret[j]) begin
                credit_nxt[j] = credit[j] - CW'(1);
            end else if (!gnt_any[j] && i_credit_ret[j]) begin
                if (credit[j] == CW'(CREDIT_DEPTH)) begin
                    err_nxt = 1'b1;
                end else begin
                    credit_nxt[j] = credit[j] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < int'(M); j++) begin
                credit[j] <= CW'(CREDIT_DEPTH);
            end
            ptr          <= '0;
            o_credit_err <= 1'b0;
        end else begin
            credit       <= credit_nxt;
            ptr          <= ptr_nxt;
            o_credit_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_credit_switch_allocator.sv
// Directed bench for credit_switch_allocator: stimulus pushes hand-computed expectations
// into a queue; a monitor pops one entry per cycle at the falling edge and compares.
module tb_credit_switch_allocator;

    localparam int unsigned N  = 5;
    localparam int unsigned M  = 5;
    localparam int unsigned CW = 3;

    typedef struct packed {
        logic [M-1:0][N-1:0]  og;
        logic [N-1:0]         ig;
        logic [M-1:0]         dv;
        logic [M-1:0][CW-1:0] cr;
        logic                 err;
    } exp_t;

    logic                 clk;
    logic                 reset;
    logic [N-1:0][M-1:0]  req;
    logic [M-1:0]         ret;
    logic [M-1:0][N-1:0]  output_grant;
    logic [N-1:0]         input_grant;
    logic [M-1:0]         data_val;
    logic [M-1:0][CW-1:0] credit;
    logic                 credit_err;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    credit_switch_allocator #(.N(N), .M(M), .CREDIT_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_output_req   (req),
        .i_credit_ret   (ret),
        .o_output_grant (output_grant),
        .o_input_grant  (input_grant),
        .o_data_val     (data_val),
        .o_credit       (credit),
        .o_credit_err   (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0][M-1:0] rq(input int i, input int o);
        logic [N-1:0][M-1:0] r;
        r       = '0;
        r[i][o] = 1'b1;
        return r;
    endfunction

    function automatic logic [M-1:0][N-1:0] g(input int o, input int i);
        logic [M-1:0][N-1:0] r;
        r       = '0;
        r[o][i] = 1'b1;
        return r;
    endfunction

    function automatic logic [M-1:0][CW-1:0] cr(input int c0, input int c1, input int c2,
                                                  input int c3, input int c4);
        logic [M-1:0][CW-1:0] r;
        r[0] = CW'(c0);
        r[1] = CW'(c1);
        r[2] = CW'(c2);
        r[3] = CW'(c3);
        r[4] = CW'(c4);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, want);
        end
    endtask

    // One cycle of stimulus plus its expected response.
    task automatic cyc(input logic r, input logic [N-1:0][M-1:0] rv, input logic [M-1:0] rt,
                       input logic [M-1:0][N-1:0] eg, input logic [M-1:0][CW-1:0] ec,
                       input logic ee);
        exp_t e;
        reset  = r;
        req    = rv;
        ret    = rt;
        e.og   = eg;
        e.ig   = '0;
        e.dv   = '0;
        e.cr   = ec;
        e.err  = ee;
        for (int j = 0; j < int'(M); j++) begin
            e.dv[j] = |eg[j];
            e.ig    = e.ig | eg[j];
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("output_grant", 32'(output_grant), 32'(e.og));
                chk("input_grant",  32'(input_grant),  32'(e.ig));
                chk("data_val",     32'(data_val),     32'(e.dv));
                chk("credit",       32'(credit),       32'(e.cr));
                chk("credit_err",   32'(credit_err),   32'(e.err));
            end
        end
    end

    initial begin : stim
        logic [N-1:0][M-1:0] r3;
        logic [M-1:0][CW-1:0] full;
        reset = 1'b1;
        req   = '0;
        ret   = '0;
        full  = cr(4, 4, 4, 4, 4);
        @(posedge clk);
        #1;

        // Reset holds grants low even with a live request.
        cyc(1'b1, rq(0, 0), '0, '0, full, 1'b0);
        cyc(1'b1, '0, '0, '0, full, 1'b0);

        // Input 1 -> output 2 drains all four credits, fifth cycle stalls.
        cyc(1'b0, rq(1, 2), '0, g(2, 1), cr(4, 4, 4, 4, 4), 1'b0);
        cyc(1'b0, rq(1, 2), '0, g(2, 1), cr(4, 4, 3, 4, 4), 1'b0);
        cyc(1'b0, rq(1, 2), '0, g(2, 1), cr(4, 4, 2, 4, 4), 1'b0);
        cyc(1'b0, rq(1, 2), '0, g(2, 1), cr(4, 4, 1, 4, 4), 1'b0);
        cyc(1'b0, rq(1, 2), '0, '0,      cr(4, 4, 0, 4, 4), 1'b0);

        // Return at zero credit: no same-cycle bypass, grant next cycle.
        cyc(1'b0, rq(1, 2), 5'b00100, '0,      cr(4, 4, 0, 4, 4), 1'b0);
        cyc(1'b0, rq(1, 2), '0,       g(2, 1), cr(4, 4, 1, 4, 4), 1'b0);
        cyc(1'b0, rq(1, 2), '0,       '0,      cr(4, 4, 0, 4, 4), 1'b0);

        // Round robin among inputs 0,2,4 on output 3 with a return every cycle.
        r3 = rq(0, 3) | rq(2, 3) | rq(4, 3);
        cyc(1'b0, r3, 5'b01000, g(3, 0), cr(4, 4, 0, 4, 4), 1'b0);
        cyc(1'b0, r3, 5'b01000, g(3, 2), cr(4, 4, 0, 4, 4), 1'b0);
        cyc(1'b0, r3, 5'b01000, g(3, 4), cr(4, 4, 0, 4, 4), 1'b0);
        cyc(1'b0, r3, 5'b01000, g(3, 0), cr(4, 4, 0, 4, 4), 1'b0);
        cyc(1'b0, r3, 5'b01000, g(3, 2), cr(4, 4, 0, 4, 4), 1'b0);
        cyc(1'b0, r3, 5'b01000, g(3, 4), cr(4, 4, 0, 4, 4), 1'b0);

        // Three independent grants in one cycle, then contention on output 1.
        cyc(1'b0, rq(1, 1) | rq(3, 3) | rq(4, 0), '0, g(1, 1) | g(3, 3) | g(0, 4),
            cr(4, 4, 0, 4, 4), 1'b0);
        cyc(1'b0, rq(1, 1) | rq(3, 1), '0, g(1, 3), cr(3, 3, 0, 3, 4), 1'b0);
        cyc(1'b0, rq(1, 1) | rq(3, 1), '0, g(1, 1), cr(3, 2, 0, 3, 4), 1'b0);

        // Multi-bit word keeps lowest output; return at full credit sets sticky error.
        cyc(1'b0, rq(2, 0) | rq(2, 3), 5'b10000, g(0, 2), cr(3, 1, 0, 3, 4), 1'b0);
        cyc(1'b0, '0, '0, '0, cr(2, 1, 0, 3, 4), 1'b1);

        // Grant plus return on output 1 leaves credit at 1 and ptr[1] at 3.
        cyc(1'b0, rq(2, 1), 5'b00010, g(1, 2), cr(2, 1, 0, 3, 4), 1'b1);
        // Asynchronous reset mid-cycle: outputs drop before any clock edge.
        cyc(1'b1, rq(0, 1) | rq(3, 1), '0, '0, full, 1'b0);
        // After release arbitration restarts from input 0.
        cyc(1'b0, rq(0, 1) | rq(3, 1), '0, g(1, 0), full, 1'b0);
        cyc(1'b0, '0, '0, '0, cr(4, 3, 4, 4, 4), 1'b0);

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
